// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide unit, one shift-add or restoring-subtract
// step per clock. Produces the same HI/LO results as the ALU MUL/DIV modes.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, mode       request and operation code (4'b0011 MUL, 4'b0100 DIV)
//   x, y              operands, sampled with an accepted start
//   busy              operation in progress; start ignored while high
//   done              one-cycle completion pulse
//   hi, lo            MUL: product upper/lower half; DIV: remainder/quotient
//   div_by_zero       last completed DIV had y == 0
module muldiv_seq #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   mode,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         div_by_zero
);

  localparam int unsigned CW       = $clog2(N) + 1;
  localparam int unsigned AW       = 2 * N + 1;
  localparam logic [3:0]  MODE_MUL = 4'b0011;
  localparam logic [3:0]  MODE_DIV = 4'b0100;
  localparam logic [CW-1:0] LAST   = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  // acc: MUL accumulator (2N+1 bits); DIV keeps the remainder in acc[N-1:0].
  logic [AW-1:0] acc, acc_nxt;
  // cst: operand held constant (multiplicand / divisor).
  logic [N-1:0]  cst, cst_nxt;
  // sh: operand shifted each step (multiplier / dividend-becoming-quotient).
  logic [N-1:0]  sh, sh_nxt;
  logic [N-1:0]  hi_nxt, lo_nxt;
  logic          dbz_nxt, busy_nxt, done_nxt;

  logic          accept;
  logic [N:0]    mul_hi;
  logic [AW-1:0] mul_acc;
  logic [N:0]    rem_s;
  logic          ge;
  logic [N-1:0]  rem_n, quo_n;

  // One shift-add multiply step.
  always_comb begin
    mul_hi  = acc[AW-1:N] + (sh[0] ? {1'b0, cst} : {(N+1){1'b0}});
    mul_acc = {mul_hi, acc[N-1:0]} >> 1;
  end

  // One restoring-divide step; rem_s needs N+1 bits since it may reach 2*y-1.
  always_comb begin
    rem_s = {acc[N-1:0], sh[N-1]};
    ge    = rem_s >= {1'b0, cst};
    rem_n = ge ? N'(rem_s - {1'b0, cst}) : rem_s[N-1:0];
    quo_n = {sh[N-2:0], ge};
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    cst_nxt   = cst;
    sh_nxt    = sh;
    hi_nxt    = hi;
    lo_nxt    = lo;
    dbz_nxt   = div_by_zero;
    accept    = start && (state == S_IDLE || state == S_DONE) &&
                (mode == MODE_MUL || mode == MODE_DIV);

    case (state)
      S_IDLE, S_DONE: begin
        if (state == S_DONE) state_nxt = S_IDLE;
        if (accept) begin
          cnt_nxt = '0;
          dbz_nxt = 1'b0;
          acc_nxt = '0;
          if (mode == MODE_MUL) begin
            cst_nxt   = x;
            sh_nxt    = y;
            state_nxt = S_MUL;
          end else if (y == '0) begin
            // Divide by zero completes immediately with the ALU's convention.
            lo_nxt    = {N{1'b1}};
            hi_nxt    = x;
            dbz_nxt   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            cst_nxt   = y;
            sh_nxt    = x;
            state_nxt = S_DIV;
          end
        end
      end
      S_MUL: begin
        acc_nxt = mul_acc;
        sh_nxt  = sh >> 1;
        cnt_nxt = cnt + CW'(1);
        if (cnt == LAST) begin
          hi_nxt    = mul_acc[2*N-1:N];
          lo_nxt    = mul_acc[N-1:0];
          state_nxt = S_DONE;
        end
      end
      S_DIV: begin
        acc_nxt = {{(N+1){1'b0}}, rem_n};
        sh_nxt  = quo_n;
        cnt_nxt = cnt + CW'(1);
        if (cnt == LAST) begin
          hi_nxt    = rem_n;
          lo_nxt    = quo_n;
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt == S_MUL) || (state_nxt == S_DIV);
    done_nxt = (state_nxt == S_DONE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      cst         <= '0;
      sh          <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      acc         <= acc_nxt;
      cst         <= cst_nxt;
      sh          <= sh_nxt;
      hi          <= hi_nxt;
      lo          <= lo_nxt;
      div_by_zero <= dbz_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (N = 32).
module tb_muldiv_seq;

  localparam logic [3:0] MUL = 4'b0011;
  localparam logic [3:0] DIV = 4'b0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  mode;
  logic [31:0] x, y;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  muldiv_seq #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .x(x), .y(y),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for done; lat counts sampled cycles before done appears.
  task automatic wait_done(output int lat, output bit found);
    lat = 0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit found);
    @(negedge clk);
    start = 1'b1; mode = m; x = a; y = b;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, found);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = 4'b0; x = '0; y = '0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    int lat; bit found;
    run_op(MUL, 32'd7, 32'd6, lat, found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL mul_timeout got=%0d exp=1", found); end
    checks++; if (lat != 32) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=32", lat); end
    checks++; if (lo !== 32'd42) begin errors++; $display("FAIL mul_lo got=%0d exp=42", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL mul_hi got=%0d exp=0", hi); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse got=%b exp=0", done); end
    run_op(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL mulmax_timeout got=%0d exp=1", found); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulmax_hi got=%h exp=fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL mulmax_lo got=%h exp=00000001", lo); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL mulmax_dbz got=%b exp=0", div_by_zero); end
  endtask

  task automatic test_div();
    int lat; bit found;
    run_op(DIV, 32'd100, 32'd7, lat, found);
    checks++; if (lat != 32) begin errors++; $display("FAIL div_busy_cycles got=%0d exp=32", lat); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL div_quo got=%0d exp=14", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL div_rem got=%0d exp=2", hi); end
    run_op(DIV, 32'd5, 32'd9, lat, found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL div_small_timeout got=%0d exp=1", found); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL div_small_quo got=%0d exp=0", lo); end
    checks++; if (hi !== 32'd5) begin errors++; $display("FAIL div_small_rem got=%0d exp=5", hi); end
  endtask

  task automatic test_div_zero();
    int lat; bit found;
    run_op(DIV, 32'd5, 32'd0, lat, found);
    checks++; if (lat != 0) begin errors++; $display("FAIL div0_latency got=%0d exp=0", lat); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo got=%h exp=ffffffff", lo); end
    checks++; if (hi !== 32'd5) begin errors++; $display("FAIL div0_hi got=%0d exp=5", hi); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL div0_flag got=%b exp=1", div_by_zero); end
    @(negedge clk);
    start = 1'b1; mode = MUL; x = 32'd3; y = 32'd3;
    @(negedge clk);
    start = 1'b0;
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL div0_clear got=%b exp=0", div_by_zero); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div0_next_busy got=%b exp=1", busy); end
    checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo_hold got=%h exp=ffffffff", lo); end
    wait_done(lat, found);
    checks++; if (lo !== 32'd9) begin errors++; $display("FAIL div0_next_lo got=%0d exp=9", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL div0_next_hi got=%0d exp=0", hi); end
  endtask

  task automatic test_bad_mode();
    @(negedge clk);
    start = 1'b1; mode = 4'b0001; x = 32'd8; y = 32'd2;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badmode_busy cyc=%0d got=%b exp=0", i, busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL badmode_done cyc=%0d got=%b exp=0", i, done); end
      @(negedge clk);
    end
    checks++; if (lo !== 32'd9) begin errors++; $display("FAIL badmode_lo got=%0d exp=9", lo); end
  endtask

  task automatic test_ignore_start();
    int lat; bit found;
    @(negedge clk);
    start = 1'b1; mode = MUL; x = 32'd7; y = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; mode = DIV; x = 32'd9; y = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, found);
    checks++; if (lat != 27) begin errors++; $display("FAIL ignore_latency got=%0d exp=27", lat); end
    checks++; if (lo !== 32'd42) begin errors++; $display("FAIL ignore_lo got=%0d exp=42", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL ignore_hi got=%0d exp=0", hi); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_queue got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat; bit found;
    run_op(MUL, 32'd2, 32'd5, lat, found);
    checks++; if (lo !== 32'd10) begin errors++; $display("FAIL b2b_first_lo got=%0d exp=10", lo); end
    start = 1'b1; mode = DIV; x = 32'd100; y = 32'd7;
    @(negedge clk);
    start = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop got=%b exp=0", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    wait_done(lat, found);
    checks++; if (lat != 32) begin errors++; $display("FAIL b2b_latency got=%0d exp=32", lat); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL b2b_quo got=%0d exp=14", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL b2b_rem got=%0d exp=2", hi); end
  endtask

  task automatic test_reset_mid();
    int lat; bit found; bit stale;
    @(negedge clk);
    start = 1'b1; mode = MUL; x = 32'd7; y = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b exp=0", done); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rstmid_hi got=%0d exp=0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rstmid_lo got=%0d exp=0", lo); end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL rstmid_stale got=%b exp=0", stale); end
    run_op(MUL, 32'd2, 32'd3, lat, found);
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL rstmid_new_lo got=%0d exp=6", lo); end
    checks++; if (lat != 32) begin errors++; $display("FAIL rstmid_new_latency got=%0d exp=32", lat); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_bad_mode();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
